// File: rtl/prbs32_checker.sv
// PRBS32 checker: hunts for seed, verifies, locks and counts errors.
// Ports: Clk, ARst, Clear, DataValid, Data in; Locked, ErrPulse,
//   BitErrCnt, WordCnt out.  Poly x^32+x^22+x^2+x^1+1, 32 shifts/word.
module prbs32_checker #(
   parameter int unsigned LOCK_COUNT   = 4,
   parameter int unsigned UNLOCK_COUNT = 4
) (
   input  logic        Clk,
   input  logic        ARst,
   input  logic        Clear,
   input  logic        DataValid,
   input  logic [31:0] Data,
   output logic        Locked,
   output logic        ErrPulse,
   output logic [31:0] BitErrCnt,
   output logic [31:0] WordCnt
);

   localparam logic [1:0] S_HUNT   = 2'd0;
   localparam logic [1:0] S_VERIFY = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;

   localparam logic [3:0] LC = 4'(LOCK_COUNT);
   localparam logic [3:0] UC = 4'(UNLOCK_COUNT);

   // Fibonacci LFSR, shift left, feedback into bit 0.
   function automatic logic [31:0] f_next(input logic [31:0] s);
      logic [31:0] v;
      v = s;
      for (int i = 0; i < 32; i++)
         v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
      return v;
   endfunction

   function automatic logic [5:0] f_pop(input logic [31:0] x);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < 32; i++)
         c = c + 6'(x[i]);
      return c;
   endfunction

   logic [1:0]  r_state;
   logic [31:0] r_exp;
   logic [3:0]  r_match_cnt;
   logic [3:0]  r_miss_cnt;
   logic        r_err;
   logic [31:0] r_bit_err_cnt;
   logic [31:0] r_word_cnt;

   logic        w_match;
   logic        w_nz;
   logic [31:0] w_next_d;
   logic [31:0] w_next_e;
   logic [3:0]  w_mc_inc;
   logic [3:0]  w_ms_inc;
   logic [32:0] w_bec_sum;
   logic [32:0] w_wc_sum;
   logic [31:0] w_bec_sat;
   logic [31:0] w_wc_sat;
   logic        w_lock_word;

   assign w_match     = (Data == r_exp);
   assign w_nz        = (Data != 32'd0);
   assign w_next_d    = f_next(Data);
   assign w_next_e    = f_next(r_exp);
   assign w_mc_inc    = r_match_cnt + 4'd1;
   assign w_ms_inc    = r_miss_cnt + 4'd1;
   assign w_lock_word = DataValid && (r_state == S_LOCKED);

   // 33-bit sums so a carry out means clamp rather than wrap.
   assign w_bec_sum = {1'b0, r_bit_err_cnt}
                    + {27'd0, f_pop(Data ^ r_exp)};
   assign w_wc_sum  = {1'b0, r_word_cnt} + 33'd1;
   assign w_bec_sat = w_bec_sum[32] ? 32'hFFFF_FFFF
                                    : w_bec_sum[31:0];
   assign w_wc_sat  = w_wc_sum[32] ? 32'hFFFF_FFFF
                                   : w_wc_sum[31:0];

   always_ff @(posedge Clk or posedge ARst) begin
      if (ARst) begin
         r_state     <= S_HUNT;
         r_exp       <= '0;
         r_match_cnt <= '0;
         r_miss_cnt  <= '0;
         r_err       <= 1'b0;
      end else begin
         r_err <= 1'b0;
         if (DataValid) begin
            unique case (r_state)
               S_HUNT: begin
                  // All-zero is the LFSR fixed point; never seed on it.
                  if (w_nz) begin
                     r_exp       <= w_next_d;
                     r_match_cnt <= '0;
                     r_state     <= S_VERIFY;
                  end
               end
               S_VERIFY: begin
                  if (w_match) begin
                     r_exp       <= w_next_d;
                     r_match_cnt <= w_mc_inc;
                     if (w_mc_inc == LC) begin
                        r_state    <= S_LOCKED;
                        r_miss_cnt <= '0;
                     end
                  end else if (w_nz) begin
                     r_exp       <= w_next_d;
                     r_match_cnt <= '0;
                  end else begin
                     r_state <= S_HUNT;
                  end
               end
               S_LOCKED: begin
                  // Free-running: errored data must not reseed.
                  r_exp <= w_next_e;
                  if (!w_match) begin
                     r_err      <= 1'b1;
                     r_miss_cnt <= w_ms_inc;
                     if (w_ms_inc == UC)
                        r_state <= S_HUNT;
                  end else begin
                     r_miss_cnt <= '0;
                  end
               end
               default: r_state <= S_HUNT;
            endcase
         end
      end
   end

   always_ff @(posedge Clk or posedge ARst) begin
      if (ARst) begin
         r_bit_err_cnt <= '0;
         r_word_cnt    <= '0;
      end else if (Clear) begin
         r_bit_err_cnt <= '0;
         r_word_cnt    <= '0;
      end else if (w_lock_word) begin
         r_word_cnt <= w_wc_sat;
         if (!w_match)
            r_bit_err_cnt <= w_bec_sat;
      end
   end

   assign Locked    = (r_state == S_LOCKED);
   assign ErrPulse  = r_err;
   assign BitErrCnt = r_bit_err_cnt;
   assign WordCnt   = r_word_cnt;

endmodule
